// File: rtl/lcd_spi_writer_pkg.sv
// Shared LCD definitions: writer state encoding, panel command bytes and
// RGB565 colour constants used by the picture and graphics generators.
package lcd_spi_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_HOLD,
    ST_DONE,
    ST_GAP
  } wr_state_t;

  // Window setup and memory write commands.
  localparam logic [7:0] LCD_CMD_CASET = 8'h2A;
  localparam logic [7:0] LCD_CMD_RASET = 8'h2B;
  localparam logic [7:0] LCD_CMD_RAMWR = 8'h2C;

  localparam logic [15:0] COLOR_BLACK  = 16'h0000;
  localparam logic [15:0] COLOR_WHITE  = 16'hFFFF;
  localparam logic [15:0] COLOR_RED    = 16'hF800;
  localparam logic [15:0] COLOR_GREEN  = 16'h07E0;
  localparam logic [15:0] COLOR_BLUE   = 16'h001F;
  localparam logic [15:0] COLOR_YELLOW = 16'hFFE0;

  // States whose duration is timed by the sclk phase counter.
  function automatic logic is_timed_phase(input wr_state_t s);
    return s inside {ST_SETUP, ST_SHIFT_LO, ST_SHIFT_HI};
  endfunction

endpackage

// File: rtl/lcd_spi_phase_cnt.sv
// Counts sys_clk cycles within one sclk half-period and strobes on the last.
module lcd_spi_phase_cnt #(
  parameter int HALF_PERIOD = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic run,
  output logic phase_end
);

  localparam logic [3:0] LAST = 4'(HALF_PERIOD - 1);

  logic [3:0] cnt;

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  assign phase_end = run && (cnt == LAST);

endmodule

// File: rtl/lcd_spi_writer.sv
// Serialises one 9-bit D/C + byte word onto a 4-wire SPI LCD, MSB first,
// with a guaranteed idle gap after each wr_done pulse.
module lcd_spi_writer
  import lcd_spi_writer_pkg::*;
#(
  parameter int HALF_PERIOD = 2,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en_write,
  input  logic [8:0] data,
  output logic       wr_done,
  output logic       busy,
  output logic       lcd_cs,
  output logic       lcd_dc,
  output logic       lcd_sclk,
  output logic       lcd_mosi
);

  localparam logic [2:0] GAP_LAST = 3'(GAP_CYCLES - 1);

  wr_state_t  state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic [2:0] gap_cnt;
  logic       phase_end;

  lcd_spi_phase_cnt #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_phase_cnt (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .run      (is_timed_phase(state)),
    .phase_end(phase_end)
  );

  // Outputs are assigned on the edge that enters a state, so each registered
  // output already shows the new state's value during that state's first cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      wr_done  <= 1'b0;
      busy     <= 1'b0;
      lcd_cs   <= 1'b1;
      lcd_dc   <= 1'b0;
      lcd_sclk <= 1'b1;
      lcd_mosi <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (en_write) begin
            shreg    <= data[7:0];
            lcd_dc   <= data[8];
            lcd_mosi <= data[7];
            lcd_cs   <= 1'b0;
            lcd_sclk <= 1'b1;
            busy     <= 1'b1;
            bit_cnt  <= '0;
            state    <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (phase_end) begin
            lcd_sclk <= 1'b0;
            lcd_mosi <= shreg[7];
            state    <= ST_SHIFT_LO;
          end
        end
        ST_SHIFT_LO: begin
          if (phase_end) begin
            lcd_sclk <= 1'b1;
            state    <= ST_SHIFT_HI;
          end
        end
        ST_SHIFT_HI: begin
          if (phase_end) begin
            if (bit_cnt == 3'd7) begin
              state <= ST_HOLD;
            end else begin
              // Next bit goes out together with the falling sclk edge.
              bit_cnt  <= bit_cnt + 3'd1;
              shreg    <= {shreg[6:0], 1'b0};
              lcd_mosi <= shreg[6];
              lcd_sclk <= 1'b0;
              state    <= ST_SHIFT_LO;
            end
          end
        end
        ST_HOLD: begin
          wr_done <= 1'b1;
          lcd_cs  <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          gap_cnt <= '0;
          state   <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Directed bench for lcd_spi_writer: one instance at HALF_PERIOD=2, one at 1,
// a vector table for single bytes plus streaming and mid-byte reset sequences.
module tb_lcd_spi_writer;

  localparam int GAP = 2;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       en [2];
  logic [8:0] din [2];
  logic [1:0] done, busy, cs, dc, sclk, mosi;

  int checks = 0;
  int failures = 0;
  int prot_err = 0;

  always #5 sys_clk = ~sys_clk;

  lcd_spi_writer #(.HALF_PERIOD(2), .GAP_CYCLES(GAP)) dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en_write(en[0]), .data(din[0]),
    .wr_done(done[0]), .busy(busy[0]), .lcd_cs(cs[0]), .lcd_dc(dc[0]),
    .lcd_sclk(sclk[0]), .lcd_mosi(mosi[0])
  );

  lcd_spi_writer #(.HALF_PERIOD(1), .GAP_CYCLES(GAP)) dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .en_write(en[1]), .data(din[1]),
    .wr_done(done[1]), .busy(busy[1]), .lcd_cs(cs[1]), .lcd_dc(dc[1]),
    .lcd_sclk(sclk[1]), .lcd_mosi(mosi[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs(input int i);
    return {cs[i], sclk[i], mosi[i], dc[i], done[i], busy[i]};
  endfunction

  // Protocol watch on both instances, sampled mid-cycle.
  logic [1:0] p_cs, p_sclk, p_mosi, p_done;
  bit p_valid = 1'b0;
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      p_valid = 1'b0;
    end else begin
      if (p_valid) begin
        for (int k = 0; k < 2; k++) begin
          if (p_sclk[k] && !p_cs[k] && sclk[k] && !cs[k] && mosi[k] !== p_mosi[k]) prot_err++;
          if (sclk[k] !== p_sclk[k] && (p_cs[k] || cs[k])) prot_err++;
          if (done[k] && p_done[k]) prot_err++;
        end
      end
      p_cs = cs; p_sclk = sclk; p_mosi = mosi; p_done = done;
      p_valid = 1'b1;
    end
  end

  typedef struct {
    int         inst;
    logic [8:0] d;
    int         drop_cyc;
    logic [8:0] new_d;
    logic       exp_dc;
    logic [7:0] exp_byte;
    int         exp_done;
  } vec_t;

  vec_t vecs [6];

  // Captures one byte and follows it until the first idle cycle after GAP.
  task automatic run_vec(input int n);
    vec_t v = vecs[n];
    int i = v.inst;
    logic [7:0] bits = '0;
    int nedge = 0, done_at = 0, ndone = 0, cs_low = 0;
    logic dc1 = 1'b0, dc_moved = 1'b0, prev_s = 1'b1;
    logic busy_last = 1'b0, busy_after = 1'b1;
    @(negedge sys_clk);
    en[i] = 1'b1;
    din[i] = v.d;
    @(posedge sys_clk);
    for (int k = 1; k <= 80; k++) begin
      @(negedge sys_clk);
      if (k == v.drop_cyc) begin
        en[i] = 1'b0;
        din[i] = v.new_d;
      end
      if (k == 1) dc1 = dc[i];
      if (!cs[i]) begin
        cs_low++;
        if (dc[i] !== dc1) dc_moved = 1'b1;
      end
      if (sclk[i] && !prev_s) begin
        if (nedge < 8) bits = {bits[6:0], mosi[i]};
        nedge++;
      end
      prev_s = sclk[i];
      if (done[i]) begin
        ndone++;
        if (done_at == 0) done_at = k;
      end
      if (done_at != 0 && k == done_at + GAP) busy_last = busy[i];
      if (done_at != 0 && k == done_at + GAP + 1) begin
        busy_after = busy[i];
        break;
      end
    end
    en[i] = 1'b0;
    check($sformatf("v%0d_dc", n), dc1, v.exp_dc);
    check($sformatf("v%0d_byte", n), bits, v.exp_byte);
    check($sformatf("v%0d_edges", n), nedge, 8);
    check($sformatf("v%0d_done_cycle", n), done_at, v.exp_done);
    check($sformatf("v%0d_done_count", n), ndone, 1);
    check($sformatf("v%0d_cs_low_cycles", n), cs_low, v.exp_done - 1);
    check($sformatf("v%0d_dc_stable", n), dc_moved, 1'b0);
    check($sformatf("v%0d_busy_last_gap", n), busy_last, 1'b1);
    check($sformatf("v%0d_busy_idle", n), busy_after, 1'b0);
  endtask

  logic [8:0] words [11];

  initial begin
    logic [7:0] acc;
    logic       sdc, prev;
    logic [8:0] w;
    int         idx, last_done, chg_at;

    en[0] = 1'b0; en[1] = 1'b0;
    din[0] = '0;  din[1] = '0;

    vecs[0] = '{0, 9'h02A, 1,  9'h1D5, 1'b0, 8'h2A, 36};
    vecs[1] = '{1, 9'h1EF, 1,  9'h010, 1'b1, 8'hEF, 19};
    vecs[2] = '{0, 9'h155, 10, 9'h000, 1'b1, 8'h55, 36};
    vecs[3] = '{1, 9'h0A5, 1,  9'h15A, 1'b0, 8'hA5, 19};
    vecs[4] = '{0, 9'h1C3, 1,  9'h03C, 1'b1, 8'hC3, 36};
    vecs[5] = '{0, 9'h081, 1,  9'h17E, 1'b0, 8'h81, 36};

    words = '{9'h02A, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02B,
              9'h100, 9'h100, 9'h101, 9'h13F, 9'h02C};

    // Reset values while held in reset, across clock edges.
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset_outs_hp2", outs(0), 6'b110000);
    check("reset_outs_hp1", outs(1), 6'b110000);
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("no_capture_without_en", busy, 2'b00);

    for (int n = 0; n < 5; n++) run_vec(n);

    // Streaming: en held high, next word presented 2 cycles after each wr_done.
    @(negedge sys_clk);
    en[0] = 1'b1;
    din[0] = words[0];
    idx = 0; acc = '0; sdc = 1'b0; prev = 1'b1; last_done = -1; chg_at = -1;
    for (int t = 0; t < 600 && idx < 11; t++) begin
      @(negedge sys_clk);
      if (t == chg_at) din[0] = words[idx];
      if (sclk[0] && !prev && !cs[0]) begin
        acc = {acc[6:0], mosi[0]};
        sdc = dc[0];
      end
      prev = sclk[0];
      if (done[0]) begin
        w = words[idx];
        check($sformatf("stream%0d_byte", idx), acc, w[7:0]);
        check($sformatf("stream%0d_dc", idx), sdc, w[8]);
        if (idx > 0) check($sformatf("stream%0d_spacing", idx), t - last_done, 39);
        last_done = t;
        idx++;
        if (idx == 11) en[0] = 1'b0;
        else chg_at = t + 2;
      end
    end
    check("stream_word_count", idx, 11);
    repeat (6) @(negedge sys_clk);
    check("stream_stops", busy[0], 1'b0);

    // Reset in cycle 20 of a byte, then a fresh capture.
    @(negedge sys_clk);
    en[0] = 1'b1;
    din[0] = 9'h1FF;
    @(posedge sys_clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge sys_clk);
      if (k == 1) en[0] = 1'b0;
    end
    check("pre_reset_active", {cs[0], dc[0], mosi[0]}, 3'b011);
    #1 sys_rst_n = 1'b0;
    #1;
    check("reset_mid_async", outs(0), 6'b110000);
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_mid_held", outs(0), 6'b110000);
    @(negedge sys_clk);
    #1 sys_rst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("post_reset_idle", busy[0], 1'b0);
    run_vec(5);

    check("protocol", prot_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
